intrapred_sched: RTL and testbench

Frame-level scheduler for the intra-prediction datapath. On a start pulse it walks every macroblock of a frame in raster order. For each macroblock it:
- sequences the 16 luma 4x4 sub-blocks serially, because each sub-block needs the previous one's result;
- runs one combined luma 16x16 / chroma 8x8 pass;
- emits one packed mode record per macroblock to the downstream entropy/transform stage over a valid/ready handshake.

It is the only driver of the datapath's `enable`, `mbnumber` and sub-block index.

---
 rtl/intrapred_pkg.sv | 35 +++
 rtl/intrapred_sched.sv | 185 ++++++++++++++++++
 tb/tb_intrapred_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/intrapred_pkg.sv
// Shared types and constants for the intra-prediction scheduler: FSM states,
// mode field widths and the packed per-macroblock mode record.
package intrapred_pkg;

    localparam int LUMA4X4_BLOCKS = 16;
    localparam int MODE4_W        = 3;
    localparam int MODE_W         = 2;

    localparam int MB_NUMBER_BITS_DEF = 12;
    localparam int REC_MB_W           = MB_NUMBER_BITS_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE4,
        ST_WAIT4,
        ST_ISSUE16,
        ST_WAIT16,
        ST_EMIT,
        ST_DONE
    } state_t;

    // mode4[n] lands at bits [3n+2:3n] of the mode4 field.
    typedef struct packed {
        logic [REC_MB_W-1:0]                     mb;
        logic [LUMA4X4_BLOCKS-1:0][MODE4_W-1:0]  mode4;
        logic [MODE_W-1:0]                       mode16;
        logic [MODE_W-1:0]                       modecb;
        logic [MODE_W-1:0]                       modecr;
    } intrapred_rec_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WAIT4) || (s == ST_WAIT16);
    endfunction

endpackage

// File: rtl/intrapred_sched.sv
// Frame-level intra-prediction scheduler: walks macroblocks in raster order,
// serialises the sixteen 4x4 luma passes, runs the 16x16/chroma pass, emits one record.
module intrapred_sched
    import intrapred_pkg::*;
#(
    parameter int MB_NUMBER_BITS = MB_NUMBER_BITS_DEF,
    parameter int MB_COUNT       = 99,
    parameter int LAT            = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_abort,
    output logic                          o_busy,
    output logic                          o_dp_enable,
    output logic [MB_NUMBER_BITS:0]       o_dp_mbnumber,
    output logic [3:0]                    o_dp_blk4,
    output logic                          o_dp_pass16,
    input  logic [MODE4_W-1:0]            i_mode4,
    input  logic [MODE_W-1:0]             i_mode16,
    input  logic [MODE_W-1:0]             i_modecb,
    input  logic [MODE_W-1:0]             i_modecr,
    output logic                          o_rec_valid,
    input  logic                          i_rec_ready,
    output logic [MB_NUMBER_BITS:0]       o_rec_mb,
    output logic [LUMA4X4_BLOCKS*MODE4_W-1:0] o_rec_mode4,
    output logic [MODE_W-1:0]             o_rec_mode16,
    output logic [MODE_W-1:0]             o_rec_modecb,
    output logic [MODE_W-1:0]             o_rec_modecr,
    output logic                          o_frame_done
);

    localparam int MBW    = MB_NUMBER_BITS + 1;
    localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [MBW-1:0]    MB_LAST   = MBW'(MB_COUNT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAT - 1);
    localparam logic [3:0]        BLK_LAST  = 4'(LUMA4X4_BLOCKS - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [WAIT_W-1:0] r_wait;
    logic [3:0]     r_blk;
    logic [MBW-1:0] r_mb;
    logic           r_pass16;
    intrapred_rec_t r_rec;

    logic w_wait_last;
    logic w_abort;
    logic w_accept;
    logic w_mb_last;

    assign w_wait_last = (r_wait == WAIT_LAST);
    assign w_abort     = i_abort && (r_state != ST_IDLE);
    assign w_accept    = (r_state == ST_EMIT) && i_rec_ready;
    assign w_mb_last   = (r_mb == MB_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_dp_enable  = 1'b0;
        o_rec_valid  = 1'b0;
        o_frame_done = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_ISSUE4;
                end
            end
            ST_ISSUE4: begin
                o_dp_enable  = 1'b1;
                w_state_next = ST_WAIT4;
            end
            ST_WAIT4: begin
                if (w_wait_last) begin
                    w_state_next = (r_blk == BLK_LAST) ? ST_ISSUE16 : ST_ISSUE4;
                end
            end
            ST_ISSUE16: begin
                o_dp_enable  = 1'b1;
                w_state_next = ST_WAIT16;
            end
            ST_WAIT16: begin
                if (w_wait_last) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                o_rec_valid = 1'b1;
                if (i_rec_ready) begin
                    w_state_next = w_mb_last ? ST_DONE : ST_ISSUE4;
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Abort beats everything, including a same-cycle downstream accept.
        if (w_abort) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait   <= '0;
            r_blk    <= '0;
            r_mb     <= '0;
            r_pass16 <= 1'b0;
            r_rec    <= '0;
        end else if (w_abort) begin
            r_wait   <= '0;
            r_blk    <= '0;
            r_mb     <= '0;
            r_pass16 <= 1'b0;
            r_rec    <= '0;
        end else begin
            r_wait <= (is_wait_state(r_state) && !w_wait_last) ? r_wait + WAIT_W'(1) : '0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_blk    <= '0;
                        r_mb     <= '0;
                        r_pass16 <= 1'b0;
                        r_rec    <= '0;
                    end
                end
                ST_WAIT4: begin
                    if (w_wait_last) begin
                        r_rec.mode4[r_blk] <= i_mode4;
                        if (r_blk == BLK_LAST) begin
                            r_pass16 <= 1'b1;
                        end else begin
                            r_blk <= r_blk + 4'd1;
                        end
                    end
                end
                ST_WAIT16: begin
                    if (w_wait_last) begin
                        r_rec.mode16 <= i_mode16;
                        r_rec.modecb <= i_modecb;
                        r_rec.modecr <= i_modecr;
                        r_rec.mb     <= REC_MB_W'(r_mb);
                    end
                end
                ST_EMIT: begin
                    if (w_accept && !w_mb_last) begin
                        r_mb     <= r_mb + MBW'(1);
                        r_blk    <= '0;
                        r_pass16 <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_mb     <= '0;
                    r_blk    <= '0;
                    r_pass16 <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_dp_mbnumber = r_mb;
    assign o_dp_blk4     = r_blk;
    assign o_dp_pass16   = r_pass16;
    assign o_rec_mb      = MBW'(r_rec.mb);
    assign o_rec_mode4   = r_rec.mode4;
    assign o_rec_mode16  = r_rec.mode16;
    assign o_rec_modecb  = r_rec.modecb;
    assign o_rec_modecr  = r_rec.modecr;

endmodule

// File: tb/tb_intrapred_sched.sv
// Directed bench for intrapred_sched: a 2-MB/LAT=4 instance and a 1-MB/LAT=1 instance.
module tb_intrapred_sched;

    localparam int MBW = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MB_COUNT=2, LAT=4
    logic           a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b1;
    logic           a_busy, a_dp_enable, a_dp_pass16, a_rec_valid, a_frame_done;
    logic [MBW-1:0] a_dp_mbnumber, a_rec_mb;
    logic [3:0]     a_dp_blk4;
    logic [2:0]     a_mode4;
    logic [47:0]    a_rec_mode4;
    logic [1:0]     a_rec_mode16, a_rec_modecb, a_rec_modecr;
    logic [1:0]     a_mode16 = 2'd1, a_modecb = 2'd2, a_modecr = 2'd3;

    // Instance B: MB_COUNT=1, LAT=1
    logic           b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
    logic           b_busy, b_dp_enable, b_dp_pass16, b_rec_valid, b_frame_done;
    logic [MBW-1:0] b_dp_mbnumber, b_rec_mb;
    logic [3:0]     b_dp_blk4;
    logic [2:0]     b_mode4;
    logic [47:0]    b_rec_mode4;
    logic [1:0]     b_rec_mode16, b_rec_modecb, b_rec_modecr;
    logic [1:0]     b_mode16 = 2'd3, b_modecb = 2'd0, b_modecr = 2'd1;

    // Datapath stand-ins: A returns the block index, B its bitwise complement.
    assign a_mode4 = a_dp_blk4[2:0];
    assign b_mode4 = ~b_dp_blk4[2:0];

    intrapred_sched #(.MB_NUMBER_BITS(12), .MB_COUNT(2), .LAT(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_abort(a_abort),
        .o_busy(a_busy), .o_dp_enable(a_dp_enable), .o_dp_mbnumber(a_dp_mbnumber),
        .o_dp_blk4(a_dp_blk4), .o_dp_pass16(a_dp_pass16),
        .i_mode4(a_mode4), .i_mode16(a_mode16), .i_modecb(a_modecb), .i_modecr(a_modecr),
        .o_rec_valid(a_rec_valid), .i_rec_ready(a_ready), .o_rec_mb(a_rec_mb),
        .o_rec_mode4(a_rec_mode4), .o_rec_mode16(a_rec_mode16),
        .o_rec_modecb(a_rec_modecb), .o_rec_modecr(a_rec_modecr),
        .o_frame_done(a_frame_done)
    );

    intrapred_sched #(.MB_NUMBER_BITS(12), .MB_COUNT(1), .LAT(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
        .o_busy(b_busy), .o_dp_enable(b_dp_enable), .o_dp_mbnumber(b_dp_mbnumber),
        .o_dp_blk4(b_dp_blk4), .o_dp_pass16(b_dp_pass16),
        .i_mode4(b_mode4), .i_mode16(b_mode16), .i_modecb(b_modecb), .i_modecr(b_modecr),
        .o_rec_valid(b_rec_valid), .i_rec_ready(b_ready), .o_rec_mb(b_rec_mb),
        .o_rec_mode4(b_rec_mode4), .o_rec_mode16(b_rec_mode16),
        .o_rec_modecb(b_rec_modecb), .o_rec_modecr(b_rec_modecr),
        .o_frame_done(b_frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int loc, mbi, recs, dones, ens, seen;
        logic exp_en, exp_valid;

        // Reset values
        #12;
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_en", a_dp_enable, 0);
        check_eq("rst_mb", a_dp_mbnumber, 0);
        check_eq("rst_blk", a_dp_blk4, 0);
        check_eq("rst_p16", a_dp_pass16, 0);
        check_eq("rst_valid", a_rec_valid, 0);
        check_eq("rst_recmode4", a_rec_mode4, 0);
        check_eq("rst_done", a_frame_done, 0);
        check_eq("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Two-MB frame, LAT=4, no stalls
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int c = 1; c <= 175; c++) begin
            loc = (c - 1) % 86;
            mbi = (c - 1) / 86;
            exp_en    = (c <= 172) && ((loc < 80) ? (loc % 5 == 0) : (loc == 80));
            exp_valid = (c <= 172) && (loc == 85);
            check_eq("a_en", a_dp_enable, exp_en);
            check_eq("a_valid", a_rec_valid, exp_valid);
            check_eq("a_done", a_frame_done, c == 173);
            check_eq("a_busy", a_busy, c <= 173);
            if (exp_en) begin
                check_eq("a_pass16", a_dp_pass16, loc == 80);
                check_eq("a_mbnum", a_dp_mbnumber, mbi);
                if (loc < 80) check_eq("a_blk4", a_dp_blk4, loc / 5);
            end
            if (exp_valid) begin
                $display("rec A cycle=%0d mb=%0d mode4=%h m16=%0d cb=%0d cr=%0d",
                         c, a_rec_mb, a_rec_mode4, a_rec_mode16, a_rec_modecb, a_rec_modecr);
                check_eq("a_rec_mb", a_rec_mb, mbi);
                check_eq("a_rec_mode4", a_rec_mode4, 48'hFAC688FAC688);
                check_eq("a_rec_m16", a_rec_mode16, 2'd1);
                check_eq("a_rec_cb", a_rec_modecb, 2'd2);
                check_eq("a_rec_cr", a_rec_modecr, 2'd3);
            end
            if (c == 175) check_eq("a_mb_wrap", a_dp_mbnumber, 0);
            tick();
        end

        // Backpressure: 10 stall cycles at the first record
        a_ready = 1'b0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 85; i++) tick();
        for (int s = 0; s < 10; s++) begin
            check_eq("bp_valid", a_rec_valid, 1);
            check_eq("bp_no_en", a_dp_enable, 0);
            check_eq("bp_rec_mb", a_rec_mb, 0);
            check_eq("bp_mode4", a_rec_mode4, 48'hFAC688FAC688);
            check_eq("bp_m16", a_rec_mode16, 2'd1);
            tick();
        end
        a_ready = 1'b1;
        $display("rec A stalled mb=%0d accepted", a_rec_mb);
        tick();
        check_eq("bp_next_en", a_dp_enable, 1);
        check_eq("bp_next_mb", a_dp_mbnumber, 1);
        check_eq("bp_next_blk", a_dp_blk4, 0);
        check_eq("bp_next_valid", a_rec_valid, 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (a_frame_done) begin seen = 1; break; end
            tick();
        end
        check_eq("bp_frame_done", seen, 1);
        tick(); tick();

        // start held high while busy
        recs = 0; dones = 0;
        a_start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (a_rec_valid) recs++;
            if (a_frame_done) begin
                dones++;
                a_start = 1'b0;
                tick(); tick();
                break;
            end
        end
        a_start = 1'b0;
        $display("held start: records=%0d frame_done=%0d", recs, dones);
        check_eq("held_recs", recs, 2);
        check_eq("held_dones", dones, 1);
        check_eq("held_idle", a_busy, 0);

        // Abort during WAIT4 of block 7
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 36; i++) tick();
        check_eq("ab_blk7", a_dp_blk4, 7);
        check_eq("ab_wait_en", a_dp_enable, 0);
        check_eq("ab_busy_pre", a_busy, 1);
        a_abort = 1'b1; tick(); a_abort = 1'b0;
        check_eq("ab_busy", a_busy, 0);
        check_eq("ab_blk_clr", a_dp_blk4, 0);
        recs = 0; dones = 0; ens = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_rec_valid) recs++;
            if (a_frame_done) dones++;
            if (a_dp_enable) ens++;
            tick();
        end
        $display("abort: valid=%0d done=%0d enables=%0d", recs, dones, ens);
        check_eq("ab_no_valid", recs, 0);
        check_eq("ab_no_done", dones, 0);
        check_eq("ab_no_en", ens, 0);

        // Asynchronous reset during WAIT4 of block 2
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check_eq("rs_blk2", a_dp_blk4, 2);
        check_eq("rs_busy_pre", a_busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rs_busy", a_busy, 0);
        check_eq("rs_blk", a_dp_blk4, 0);
        check_eq("rs_en", a_dp_enable, 0);
        tick();
        rst_n = 1'b1;
        ens = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_dp_enable) ens++;
            tick();
        end
        check_eq("rs_no_en", ens, 0);
        check_eq("rs_idle", a_busy, 0);

        // One-MB frame, LAT=1
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            exp_en = ((c <= 31) && (c % 2 == 1)) || (c == 33);
            check_eq("b_en", b_dp_enable, exp_en);
            check_eq("b_valid", b_rec_valid, c == 35);
            check_eq("b_done", b_frame_done, c == 36);
            check_eq("b_busy", b_busy, c <= 36);
            if (exp_en) begin
                check_eq("b_pass16", b_dp_pass16, c == 33);
                if (c <= 31) check_eq("b_blk4", b_dp_blk4, (c - 1) / 2);
            end
            if (c == 35) begin
                $display("rec B cycle=%0d mb=%0d mode4=%h m16=%0d cb=%0d cr=%0d",
                         c, b_rec_mb, b_rec_mode4, b_rec_mode16, b_rec_modecb, b_rec_modecr);
                check_eq("b_rec_mb", b_rec_mb, 0);
                check_eq("b_rec_mode4", b_rec_mode4, 48'h053977053977);
                check_eq("b_rec_m16", b_rec_mode16, 2'd3);
                check_eq("b_rec_cb", b_rec_modecb, 2'd0);
                check_eq("b_rec_cr", b_rec_modecr, 2'd1);
            end
            if (c >= 37) begin
                check_eq("b_mb_zero", b_dp_mbnumber, 0);
                check_eq("b_p16_clr", b_dp_pass16, 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
